// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controllers.
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_e;

  localparam int         MD_LATENCY_DEF = 4;
  localparam logic [4:0] REG_ZERO       = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; shared by the pipeline performance counters.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}}))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, MUL/DIV EX occupancy, branch flush.
//   state   | meaning
//   RUN     | normal issue; branch/muldiv/load-use resolved combinationally
//   MD_BUSY | MUL/DIV holding EX; md_cnt counts remaining stall cycles
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEF,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IF_ID_Rs,
  input  logic [4:0]       IF_ID_Rt,
  input  logic             IF_ID_UsesRt,
  input  logic [4:0]       ID_EX_Rt,
  input  logic             ID_EX_MemRead,
  input  logic             ID_EX_MulDiv,
  input  logic             BranchTaken,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Write,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Flush,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_count
);

  localparam int MD_W = $clog2(MD_LATENCY);
  localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MD_LATENCY - 2);

  state_e          state_q, state_d;
  logic [MD_W-1:0] md_cnt_q, md_cnt_d;
  logic            load_use;

  assign load_use = ID_EX_MemRead && (ID_EX_Rt != REG_ZERO) &&
                    ((ID_EX_Rt == IF_ID_Rs) || (IF_ID_UsesRt && (ID_EX_Rt == IF_ID_Rt)));

  always_comb begin
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Write  = 1'b1;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Flush = 1'b0;
    md_busy      = 1'b0;
    md_done      = 1'b0;
    unique case (state_q)
      RUN: begin
        if (BranchTaken) begin
          IF_ID_Flush = 1'b1;
          ID_EX_Flush = 1'b1;
        end else if (ID_EX_MulDiv) begin
          md_busy      = 1'b1;
          PCWrite      = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_Write  = 1'b0;
          EX_MEM_Flush = 1'b1;
          md_cnt_d     = MD_LOAD;
          state_d      = MD_BUSY;
        end else if (load_use) begin
          PCWrite     = 1'b0;
          IF_ID_Write = 1'b0;
          ID_EX_Flush = 1'b1;
        end
      end
      MD_BUSY: begin
        // BranchTaken and ID_EX_MulDiv are deliberately ignored while EX is held
        md_busy = 1'b1;
        if (md_cnt_q != '0) begin
          PCWrite      = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_Write  = 1'b0;
          EX_MEM_Flush = 1'b1;
          md_cnt_d     = md_cnt_q - 1'b1;
        end else begin
          md_done = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~PCWrite),
    .count (stall_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: inputs driven on the falling edge, outputs checked 1ns later.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  IF_ID_Rs, IF_ID_Rt, ID_EX_Rt;
  logic        IF_ID_UsesRt, ID_EX_MemRead, ID_EX_MulDiv, BranchTaken;
  logic        PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Flush;
  logic        md_busy, md_done;
  logic [15:0] stall_count;

  int vectors    = 0;
  int miscompares = 0;

  // Output vector order: PCWrite IF_ID_Write IF_ID_Flush ID_EX_Write ID_EX_Flush EX_MEM_Flush md_busy md_done
  localparam logic [7:0] V_IDLE   = 8'b1101_0000;
  localparam logic [7:0] V_LDUSE  = 8'b0001_1000;
  localparam logic [7:0] V_MDSTL  = 8'b0000_0110;
  localparam logic [7:0] V_MDREL  = 8'b1101_0011;
  localparam logic [7:0] V_BRANCH = 8'b1111_1000;

  logic [7:0] outs;
  assign outs = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write,
                 ID_EX_Flush, EX_MEM_Flush, md_busy, md_done};

  hazard_ctrl #(.MD_LATENCY(4), .CNT_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .IF_ID_Rs      (IF_ID_Rs),
    .IF_ID_Rt      (IF_ID_Rt),
    .IF_ID_UsesRt  (IF_ID_UsesRt),
    .ID_EX_Rt      (ID_EX_Rt),
    .ID_EX_MemRead (ID_EX_MemRead),
    .ID_EX_MulDiv  (ID_EX_MulDiv),
    .BranchTaken   (BranchTaken),
    .PCWrite       (PCWrite),
    .IF_ID_Write   (IF_ID_Write),
    .IF_ID_Flush   (IF_ID_Flush),
    .ID_EX_Write   (ID_EX_Write),
    .ID_EX_Flush   (ID_EX_Flush),
    .EX_MEM_Flush  (EX_MEM_Flush),
    .md_busy       (md_busy),
    .md_done       (md_done),
    .stall_count   (stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    IF_ID_Rs = 5'd0; IF_ID_Rt = 5'd0; IF_ID_UsesRt = 1'b0;
    ID_EX_Rt = 5'd0; ID_EX_MemRead = 1'b0; ID_EX_MulDiv = 1'b0; BranchTaken = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("reset_outs", 32'(outs), 32'(V_IDLE));
    chk("reset_cnt", 32'(stall_count), 32'd0);
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("idle_outs", 32'(outs), 32'(V_IDLE));

    // load-use on Rs
    step();
    ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd8; IF_ID_Rs = 5'd8;
    #1 chk("lduse_rs", 32'(outs), 32'(V_LDUSE));
    step();
    idle_inputs();
    #1 chk("lduse_one_bubble", 32'(outs), 32'(V_IDLE));
    chk("lduse_cnt", 32'(stall_count), 32'd1);

    // destination $zero never stalls
    step();
    ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd0; IF_ID_Rs = 5'd0;
    #1 chk("lduse_r0", 32'(outs), 32'(V_IDLE));

    // Rt match only counts when Rt is a source
    step();
    ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd8; IF_ID_Rs = 5'd3; IF_ID_Rt = 5'd8; IF_ID_UsesRt = 1'b0;
    #1 chk("lduse_rt_unused", 32'(outs), 32'(V_IDLE));
    step();
    IF_ID_UsesRt = 1'b1;
    #1 chk("lduse_rt_used", 32'(outs), 32'(V_LDUSE));
    step();
    idle_inputs();
    #1 chk("lduse_rt_cnt", 32'(stall_count), 32'd2);

    // single MUL/DIV, latency 4
    step();
    ID_EX_MulDiv = 1'b1;
    #1 chk("md_c1", 32'(outs), 32'(V_MDSTL));
    step(); #1 chk("md_c2", 32'(outs), 32'(V_MDSTL));
    step(); #1 chk("md_c3", 32'(outs), 32'(V_MDSTL));
    step(); #1 chk("md_c4_release", 32'(outs), 32'(V_MDREL));
    step();
    ID_EX_MulDiv = 1'b0;
    #1 chk("md_after", 32'(outs), 32'(V_IDLE));
    chk("md_cnt", 32'(stall_count), 32'd5);

    // back-to-back MUL/DIV held for 8 cycles
    step();
    ID_EX_MulDiv = 1'b1;
    #1 chk("b2b_c1", 32'(outs), 32'(V_MDSTL));
    step(); #1 chk("b2b_c2", 32'(outs), 32'(V_MDSTL));
    step(); #1 chk("b2b_c3", 32'(outs), 32'(V_MDSTL));
    step(); #1 chk("b2b_c4_done", 32'(outs), 32'(V_MDREL));
    step(); #1 chk("b2b_c5_reentry", 32'(outs), 32'(V_MDSTL));
    step(); #1 chk("b2b_c6", 32'(outs), 32'(V_MDSTL));
    step(); #1 chk("b2b_c7", 32'(outs), 32'(V_MDSTL));
    step(); #1 chk("b2b_c8_done", 32'(outs), 32'(V_MDREL));
    step();
    ID_EX_MulDiv = 1'b0;
    #1 chk("b2b_cnt", 32'(stall_count), 32'd11);

    // branch beats load-use
    ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd8; IF_ID_Rs = 5'd8; BranchTaken = 1'b1;
    #1 chk("br_vs_lduse", 32'(outs), 32'(V_BRANCH));
    // branch beats MUL/DIV and does not enter MD_BUSY
    step();
    idle_inputs();
    BranchTaken = 1'b1; ID_EX_MulDiv = 1'b1;
    #1 chk("br_vs_md", 32'(outs), 32'(V_BRANCH));
    step();
    idle_inputs();
    #1 chk("br_no_md_state", 32'(outs), 32'(V_IDLE));
    chk("br_cnt", 32'(stall_count), 32'd11);

    // branch during MD_BUSY is ignored, then reset mid-operation
    step();
    ID_EX_MulDiv = 1'b1;
    #1 chk("mdrst_c1", 32'(outs), 32'(V_MDSTL));
    step();
    BranchTaken = 1'b1;
    #1 chk("mdrst_c2_br_ignored", 32'(outs), 32'(V_MDSTL));
    chk("mdrst_cnt_pre", 32'(stall_count), 32'd12);
    #1;
    idle_inputs();
    rst_n = 1'b0;
    #1 chk("mdrst_async", 32'(outs), 32'(V_IDLE));
    chk("mdrst_cnt", 32'(stall_count), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd12; IF_ID_Rt = 5'd12; IF_ID_UsesRt = 1'b1; IF_ID_Rs = 5'd1;
    #1 chk("post_rst_lduse", 32'(outs), 32'(V_LDUSE));
    step();
    idle_inputs();
    #1 chk("post_rst_idle", 32'(outs), 32'(V_IDLE));
    chk("post_rst_cnt", 32'(stall_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
